mem_access_unit: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register outputs: pc, inst, alu, rs2, memrw, load_type, wb_sel, regwen.
- Turns each load or store into one transaction on a valid/ready data-memory bus with variable latency.
- Formats load data and generates store byte enables.
- Holds the pipeline with o_stall until the access completes.

---
 rtl/mem_access_unit.sv | 193 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine.
// Turns each EX/MEM load or store into one valid/ready data-bus transaction,
// formats load data, builds store byte enables and stalls the pipeline until done.
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_alu/i_rs2/i_memrw/i_load_type/i_wb_sel/i_regwen : EX/MEM register fields
//   o_req_valid/i_req_ready/o_req_addr/o_req_we/o_req_be/o_req_wdata : request channel
//   i_rsp_valid/i_rsp_rdata : read response channel
//   o_ld_data : formatted load result (valid in DONE)
//   o_stall   : pipeline freeze
//   o_misalign, o_bus_err : one-cycle event pulses
module mem_access_unit #(
    parameter logic [1:0]  WB_SEL_MEM = 2'b00,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_alu,
    input  logic [31:0] i_rs2,
    input  logic        i_memrw,
    input  logic [2:0]  i_load_type,
    input  logic [1:0]  i_wb_sel,
    input  logic        i_regwen,
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic [31:0] o_req_addr,
    output logic        o_req_we,
    output logic [3:0]  o_req_be,
    output logic [31:0] o_req_wdata,
    input  logic        i_rsp_valid,
    input  logic [31:0] i_rsp_rdata,
    output logic [31:0] o_ld_data,
    output logic        o_stall,
    output logic        o_misalign,
    output logic        o_bus_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [2:0]         ld_type_q, ld_type_d;
    logic [1:0]         off_q, off_d;
    logic               req_valid_d, req_we_d, misalign_d, bus_err_d;
    logic [31:0]        req_addr_d, req_wdata_d, ld_data_d;
    logic [3:0]         req_be_d;

    logic               access_c, misal_c, timeout_hit;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c, fmt_c;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;

    // Decode the incoming access: size from funct3[1:0], 2'b11 behaves as a word
    always_comb begin
        access_c = i_memrw || (i_wb_sel == WB_SEL_MEM && i_regwen);
        misal_c  = 1'b0;
        be_c     = 4'b1111;
        wdata_c  = i_rs2;
        case (i_load_type[1:0])
            2'b00: begin
                be_c    = 4'b0001 << i_alu[1:0];
                wdata_c = {4{i_rs2[7:0]}};
            end
            2'b01: begin
                misal_c = i_alu[0];
                be_c    = 4'b0011 << i_alu[1:0];
                wdata_c = {2{i_rs2[15:0]}};
            end
            default: misal_c = (i_alu[1:0] != 2'b00);
        endcase
    end

    // Load formatting from the latched size/offset
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = i_rsp_rdata[7:0];
            2'd1:    ld_byte = i_rsp_rdata[15:8];
            2'd2:    ld_byte = i_rsp_rdata[23:16];
            default: ld_byte = i_rsp_rdata[31:24];
        endcase
        ld_half = off_q[1] ? i_rsp_rdata[31:16] : i_rsp_rdata[15:0];
        case (ld_type_q)
            3'b000:  fmt_c = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  fmt_c = {{16{ld_half[15]}}, ld_half};
            3'b100:  fmt_c = {24'd0, ld_byte};
            3'b101:  fmt_c = {16'd0, ld_half};
            default: fmt_c = i_rsp_rdata;
        endcase
    end

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

    // Stall is combinational in IDLE so the access is held the same cycle it appears
    assign o_stall = i_reset && ((state_q == S_REQ) || (state_q == S_WAIT) ||
                     ((state_q == S_IDLE) && access_c && !misal_c));

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ld_type_d   = ld_type_q;
        off_d       = off_q;
        req_valid_d = 1'b0;
        req_addr_d  = o_req_addr;
        req_we_d    = o_req_we;
        req_be_d    = o_req_be;
        req_wdata_d = o_req_wdata;
        ld_data_d   = o_ld_data;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access_c && misal_c) begin
                    misalign_d = 1'b1;
                end else if (access_c) begin
                    state_d     = S_REQ;
                    cnt_d       = '0;
                    req_valid_d = 1'b1;
                    req_addr_d  = {i_alu[31:2], 2'b00};
                    req_we_d    = i_memrw;
                    req_be_d    = i_memrw ? be_c : 4'b0000;
                    req_wdata_d = i_memrw ? wdata_c : 32'd0;
                    ld_type_d   = i_load_type;
                    off_d       = i_alu[1:0];
                end
            end
            S_REQ: begin
                cnt_d       = cnt_inc;
                req_valid_d = 1'b1;
                if (i_req_ready && o_req_we) begin
                    req_valid_d = 1'b0;
                    state_d     = S_DONE;
                end else if (timeout_hit) begin
                    req_valid_d = 1'b0;
                    bus_err_d   = 1'b1;
                    ld_data_d   = 32'd0;
                    state_d     = S_DONE;
                end else if (i_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (i_rsp_valid) begin
                    ld_data_d = fmt_c;
                    state_d   = S_DONE;
                end else if (timeout_hit) begin
                    bus_err_d = 1'b1;
                    ld_data_d = 32'd0;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ld_type_q   <= 3'b000;
            off_q       <= 2'b00;
            o_req_valid <= 1'b0;
            o_req_addr  <= 32'd0;
            o_req_we    <= 1'b0;
            o_req_be    <= 4'b0000;
            o_req_wdata <= 32'd0;
            o_ld_data   <= 32'd0;
            o_misalign  <= 1'b0;
            o_bus_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ld_type_q   <= ld_type_d;
            off_q       <= off_d;
            o_req_valid <= req_valid_d;
            o_req_addr  <= req_addr_d;
            o_req_we    <= req_we_d;
            o_req_be    <= req_be_d;
            o_req_wdata <= req_wdata_d;
            o_ld_data   <= ld_data_d;
            o_misalign  <= misalign_d;
            o_bus_err   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (default TIMEOUT plus a TIMEOUT=4 copy).
module tb_mem_access_unit;

    logic        i_clk;
    logic        i_reset;
    logic [31:0] i_alu, i_rs2, i_rsp_rdata;
    logic        i_memrw, i_regwen, i_req_ready, i_rsp_valid;
    logic [2:0]  i_load_type;
    logic [1:0]  i_wb_sel;

    logic        o_req_valid, o_req_we, o_stall, o_misalign, o_bus_err;
    logic [31:0] o_req_addr, o_req_wdata, o_ld_data;
    logic [3:0]  o_req_be;

    logic        to_req_valid, to_req_we, to_stall, to_misalign, to_bus_err;
    logic [31:0] to_req_addr, to_req_wdata, to_ld_data;
    logic [3:0]  to_req_be;

    int checks = 0;
    int passed = 0;

    mem_access_unit u_dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_alu(i_alu), .i_rs2(i_rs2),
        .i_memrw(i_memrw), .i_load_type(i_load_type), .i_wb_sel(i_wb_sel), .i_regwen(i_regwen),
        .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_addr(o_req_addr),
        .o_req_we(o_req_we), .o_req_be(o_req_be), .o_req_wdata(o_req_wdata),
        .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata), .o_ld_data(o_ld_data),
        .o_stall(o_stall), .o_misalign(o_misalign), .o_bus_err(o_bus_err)
    );

    mem_access_unit #(.WB_SEL_MEM(2'b00), .TIMEOUT(4)) u_to (
        .i_clk(i_clk), .i_reset(i_reset), .i_alu(i_alu), .i_rs2(i_rs2),
        .i_memrw(i_memrw), .i_load_type(i_load_type), .i_wb_sel(i_wb_sel), .i_regwen(i_regwen),
        .o_req_valid(to_req_valid), .i_req_ready(i_req_ready), .o_req_addr(to_req_addr),
        .o_req_we(to_req_we), .o_req_be(to_req_be), .o_req_wdata(to_req_wdata),
        .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata), .o_ld_data(to_ld_data),
        .o_stall(to_stall), .o_misalign(to_misalign), .o_bus_err(to_bus_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic bubble;
        i_alu = 32'd0; i_rs2 = 32'd0; i_memrw = 1'b0; i_load_type = 3'b000;
        i_wb_sel = 2'b00; i_regwen = 1'b0; i_req_ready = 1'b0;
        i_rsp_valid = 1'b0; i_rsp_rdata = 32'd0;
    endtask

    task automatic test_reset;
        bubble();
        i_reset = 1'b0;
        tick(); tick();
        checks++;
        if ({o_req_valid, o_stall, o_req_we, o_misalign, o_bus_err, o_req_be} !== 9'd0 ||
            o_req_addr !== 32'd0 || o_req_wdata !== 32'd0 || o_ld_data !== 32'd0)
            $display("FAIL reset_outputs: got valid=%b stall=%b addr=%h ld=%h want all 0",
                     o_req_valid, o_stall, o_req_addr, o_ld_data);
        else passed++;
        i_reset = 1'b1;
        tick();
    endtask

    task automatic store_seq(input string name, input logic [31:0] addr, input logic [2:0] lt,
                             input logic [31:0] rs2, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata);
        bubble();
        i_memrw = 1'b1; i_load_type = lt; i_alu = addr; i_rs2 = rs2; i_req_ready = 1'b1;
        #1;
        checks++;
        if (o_stall !== 1'b1 || o_req_valid !== 1'b0)
            $display("FAIL %s idle_stall: got stall=%b valid=%b want 1/0", name, o_stall, o_req_valid);
        else passed++;
        tick();
        checks++;
        if (o_req_valid !== 1'b1 || o_req_we !== 1'b1 || o_req_addr !== {addr[31:2], 2'b00} ||
            o_req_be !== exp_be || o_req_wdata !== exp_wdata || o_stall !== 1'b1)
            $display("FAIL %s req: got v=%b we=%b addr=%h be=%b wd=%h st=%b want 1 1 %h %b %h 1",
                     name, o_req_valid, o_req_we, o_req_addr, o_req_be, o_req_wdata, o_stall,
                     {addr[31:2], 2'b00}, exp_be, exp_wdata);
        else passed++;
        tick();
        checks++;
        if (o_stall !== 1'b0 || o_req_valid !== 1'b0)
            $display("FAIL %s done: got stall=%b valid=%b want 0/0", name, o_stall, o_req_valid);
        else passed++;
        bubble();
        tick();
        checks++;
        if (o_stall !== 1'b0 || o_req_valid !== 1'b0)
            $display("FAIL %s after_done: got stall=%b valid=%b want 0/0", name, o_stall, o_req_valid);
        else passed++;
    endtask

    task automatic load_seq(input string name, input logic [31:0] addr, input logic [2:0] lt,
                            input logic [31:0] rdata, input int nwait, input logic [31:0] exp);
        bubble();
        i_regwen = 1'b1; i_wb_sel = 2'b00; i_load_type = lt; i_alu = addr; i_req_ready = 1'b1;
        #1;
        checks++;
        if (o_stall !== 1'b1)
            $display("FAIL %s idle_stall: got %b want 1", name, o_stall);
        else passed++;
        tick();
        checks++;
        if (o_req_valid !== 1'b1 || o_req_we !== 1'b0 || o_req_be !== 4'b0000 ||
            o_req_addr !== {addr[31:2], 2'b00})
            $display("FAIL %s req: got v=%b we=%b be=%b addr=%h want 1 0 0000 %h",
                     name, o_req_valid, o_req_we, o_req_be, o_req_addr, {addr[31:2], 2'b00});
        else passed++;
        // A response during REQ must be ignored
        i_rsp_valid = 1'b1; i_rsp_rdata = 32'h5A5A_5A5A;
        tick();
        i_rsp_valid = 1'b0;
        for (int k = 1; k < nwait; k++) begin
            checks++;
            if (o_stall !== 1'b1 || o_req_valid !== 1'b0)
                $display("FAIL %s wait%0d: got stall=%b valid=%b want 1/0", name, k, o_stall, o_req_valid);
            else passed++;
            tick();
        end
        i_rsp_valid = 1'b1; i_rsp_rdata = rdata;
        tick();
        i_rsp_valid = 1'b0; i_rsp_rdata = 32'd0;
        checks++;
        if (o_stall !== 1'b0 || o_ld_data !== exp)
            $display("FAIL %s done: got stall=%b ld=%h want 0 %h", name, o_stall, o_ld_data, exp);
        else passed++;
        bubble();
        tick();
        checks++;
        if (o_stall !== 1'b0 || o_req_valid !== 1'b0)
            $display("FAIL %s after_done: got stall=%b valid=%b want 0/0", name, o_stall, o_req_valid);
        else passed++;
    endtask

    task automatic test_stores;
        store_seq("sw",  32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        store_seq("sb",  32'h0000_0103, 3'b000, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
        store_seq("sh",  32'h0000_0102, 3'b001, 32'h0000_1234, 4'b1100, 32'h1234_1234);
        store_seq("sb1", 32'h0000_0101, 3'b000, 32'h1234_5677, 4'b0010, 32'h7777_7777);
    endtask

    task automatic test_loads;
        load_seq("lb",  32'h0000_0101, 3'b000, 32'h0000_80FF, 3, 32'hFFFF_FF80);
        load_seq("lbu", 32'h0000_0101, 3'b100, 32'h0000_80FF, 1, 32'h0000_0080);
        load_seq("lhu", 32'h0000_0102, 3'b101, 32'h8001_0000, 1, 32'h0000_8001);
        load_seq("lh",  32'h0000_0102, 3'b001, 32'h8001_0000, 2, 32'hFFFF_8001);
        load_seq("lw",  32'h0000_0104, 3'b010, 32'h1234_5678, 1, 32'h1234_5678);
        load_seq("lunk", 32'h0000_0108, 3'b111, 32'hCAFE_0001, 1, 32'hCAFE_0001);
    endtask

    task automatic test_misalign_bubble;
        bubble();
        i_regwen = 1'b1; i_load_type = 3'b010; i_alu = 32'h0000_0102; i_req_ready = 1'b1;
        #1;
        checks++;
        if (o_stall !== 1'b0)
            $display("FAIL lw_misal stall: got %b want 0", o_stall);
        else passed++;
        tick();
        bubble();
        #1;
        checks++;
        if (o_misalign !== 1'b1 || o_req_valid !== 1'b0 || o_stall !== 1'b0)
            $display("FAIL lw_misal pulse: got mis=%b valid=%b stall=%b want 1 0 0",
                     o_misalign, o_req_valid, o_stall);
        else passed++;
        tick();
        checks++;
        if (o_misalign !== 1'b0 || o_req_valid !== 1'b0)
            $display("FAIL lw_misal end: got mis=%b valid=%b want 0 0", o_misalign, o_req_valid);
        else passed++;
        // Misaligned halfword store
        i_memrw = 1'b1; i_load_type = 3'b001; i_alu = 32'h0000_0201; i_req_ready = 1'b1;
        #1;
        checks++;
        if (o_stall !== 1'b0)
            $display("FAIL sh_misal stall: got %b want 0", o_stall);
        else passed++;
        tick();
        bubble();
        #1;
        checks++;
        if (o_misalign !== 1'b1 || o_req_valid !== 1'b0)
            $display("FAIL sh_misal pulse: got mis=%b valid=%b want 1 0", o_misalign, o_req_valid);
        else passed++;
        // Bubble: all-zero inputs
        tick();
        checks++;
        if (o_stall !== 1'b0 || o_req_valid !== 1'b0 || o_misalign !== 1'b0)
            $display("FAIL bubble: got stall=%b valid=%b mis=%b want 0 0 0", o_stall, o_req_valid, o_misalign);
        else passed++;
        tick();
        checks++;
        if (o_req_valid !== 1'b0)
            $display("FAIL bubble_req: got valid=%b want 0", o_req_valid);
        else passed++;
    endtask

    task automatic test_backpressure;
        bubble();
        i_memrw = 1'b1; i_load_type = 3'b010; i_alu = 32'h0000_0104; i_rs2 = 32'h0BAD_F00D;
        i_req_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (o_req_valid !== 1'b1 || o_req_addr !== 32'h0000_0104 || o_req_wdata !== 32'h0BAD_F00D ||
                o_req_be !== 4'b1111 || o_req_we !== 1'b1 || o_stall !== 1'b1)
                $display("FAIL bp_hold%0d: got v=%b addr=%h wd=%h be=%b st=%b want 1 104 0badf00d 1111 1",
                         k, o_req_valid, o_req_addr, o_req_wdata, o_req_be, o_stall);
            else passed++;
            if (k == 4) i_req_ready = 1'b1;
            tick();
        end
        checks++;
        if (o_stall !== 1'b0 || o_req_valid !== 1'b0)
            $display("FAIL bp_done: got stall=%b valid=%b want 0 0", o_stall, o_req_valid);
        else passed++;
        bubble();
        tick();
    endtask

    task automatic test_timeout;
        bubble();
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        tick();
        // Seed a nonzero result so the cleared data is observable
        load_seq("lw_seed", 32'h0000_0200, 3'b010, 32'h1357_9BDF, 1, 32'h1357_9BDF);
        checks++;
        if (to_ld_data !== 32'h1357_9BDF)
            $display("FAIL to_seed: got %h want 13579bdf", to_ld_data);
        else passed++;
        i_regwen = 1'b1; i_load_type = 3'b010; i_alu = 32'h0000_0200; i_req_ready = 1'b1;
        tick();
        checks++;
        if (to_req_valid !== 1'b1)
            $display("FAIL to_req: got %b want 1", to_req_valid);
        else passed++;
        tick(); tick(); tick();
        checks++;
        if (to_stall !== 1'b1 || to_bus_err !== 1'b0)
            $display("FAIL to_wait3: got stall=%b err=%b want 1 0", to_stall, to_bus_err);
        else passed++;
        tick();
        checks++;
        if (to_bus_err !== 1'b1 || to_ld_data !== 32'd0 || to_stall !== 1'b0 || to_req_valid !== 1'b0)
            $display("FAIL to_done: got err=%b ld=%h stall=%b valid=%b want 1 0 0 0",
                     to_bus_err, to_ld_data, to_stall, to_req_valid);
        else passed++;
        bubble();
        tick();
        checks++;
        if (to_bus_err !== 1'b0 || to_stall !== 1'b0)
            $display("FAIL to_after: got err=%b stall=%b want 0 0", to_bus_err, to_stall);
        else passed++;
        // Default-TIMEOUT unit is still waiting; reset both to realign
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_midflight;
        load_seq("lw_pre", 32'h0000_0300, 3'b010, 32'h2468_ACE0, 1, 32'h2468_ACE0);
        bubble();
        i_regwen = 1'b1; i_load_type = 3'b010; i_alu = 32'h0000_0300; i_req_ready = 1'b1;
        tick();   // REQ
        tick();   // WAIT
        tick();   // WAIT
        i_reset = 1'b0;
        #1;
        checks++;
        if ({o_req_valid, o_stall, o_req_we, o_misalign, o_bus_err, o_req_be} !== 9'd0 ||
            o_req_addr !== 32'd0 || o_req_wdata !== 32'd0 || o_ld_data !== 32'd0)
            $display("FAIL rst_wait: got valid=%b stall=%b addr=%h ld=%h want all 0",
                     o_req_valid, o_stall, o_req_addr, o_ld_data);
        else passed++;
        bubble();
        tick();
        i_reset = 1'b1;
        i_rsp_valid = 1'b1; i_rsp_rdata = 32'hBAD0_BAD0;
        tick();
        i_rsp_valid = 1'b0;
        checks++;
        if (o_stall !== 1'b0 || o_ld_data !== 32'd0 || o_req_valid !== 1'b0)
            $display("FAIL rst_late_rsp: got stall=%b ld=%h valid=%b want 0 0 0",
                     o_stall, o_ld_data, o_req_valid);
        else passed++;
        load_seq("lw_post", 32'h0000_0100, 3'b010, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
    endtask

    initial begin
        i_reset = 1'b0;
        bubble();
        test_reset();
        test_stores();
        test_loads();
        test_misalign_bubble();
        test_backpressure();
        test_timeout();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
